// File: rtl/gnrc_stream_dispatch_pkg.sv
// Shared types for the credit-gated round-robin stream dispatcher.
// Holds the FSM state encoding and a small modulo helper.
package gnrc_stream_dispatch_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  function automatic int unsigned wrap_inc(
    input int unsigned v,
    input int unsigned n
  );
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/gnrc_stream_demux.sv
// Combinational 1-to-N stream demux with broadcast payload.
// The selected port sees valid; the source sees that port's ready.
module gnrc_stream_demux #(
  parameter int  N     = 4,
  parameter type DTYPE = logic,
  parameter int  AW    = $clog2(N)
) (
  input  logic [AW-1:0] sel_i,
  input  DTYPE          data_i,
  input  logic          valid_i,
  input  logic          last_i,
  output logic          ready_o,
  output DTYPE          data_o [N],
  output logic [N-1:0]  valid_o,
  output logic [N-1:0]  last_o,
  input  logic [N-1:0]  ready_i
);

  always_comb begin
    valid_o        = '0;
    valid_o[sel_i] = valid_i;
  end

  assign ready_o = ready_i[sel_i];
  assign last_o  = {N{last_i}};

  for (genvar k = 0; k < N; k++) begin : g_data
    assign data_o[k] = data_i;
  end

endmodule

// File: rtl/gnrc_stream_dispatch.sv
// Packet dispatcher: locks each input packet to one output chosen
// round-robin among outputs that still hold packet credit.
module gnrc_stream_dispatch
  import gnrc_stream_dispatch_pkg::*;
#(
  parameter int  N          = 4,
  parameter type DTYPE      = logic,
  parameter int  MAX_CREDIT = 4,
  localparam int AW         = $clog2(N),
  localparam int CW         = $clog2(MAX_CREDIT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  DTYPE          data_i,
  input  logic          valid_i,
  input  logic          last_i,
  output logic          ready_o,
  output DTYPE          data_o [N],
  output logic [N-1:0]  valid_o,
  output logic [N-1:0]  last_o,
  input  logic [N-1:0]  ready_i,
  input  logic [N-1:0]  credit_ret_i,
  output logic [AW-1:0] dest_o,
  output logic          busy_o
);

  localparam logic [CW-1:0] CMAX = CW'(MAX_CREDIT);

  state_e        state_q, state_d;
  logic [AW-1:0] dest_q, dest_d;
  logic [AW-1:0] rr_q, rr_d;
  logic [AW-1:0] pick;
  logic          found;
  logic [CW-1:0] credit_q [N];
  logic [CW-1:0] credit_d [N];

  logic stream;
  logic dmx_valid;
  logic dmx_ready;
  logic hs_last;

  // Reset masks the outputs in the same cycle it is asserted.
  assign stream    = (state_q == STREAM) && !rst_i;
  assign dmx_valid = valid_i && stream;
  assign ready_o   = dmx_ready && stream;
  assign hs_last   = valid_i && ready_o && last_i;
  assign busy_o    = stream;
  assign dest_o    = rst_i ? '0 : dest_q;

  always_comb begin : picker
    int j;
    found = 1'b0;
    pick  = rr_q;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(rr_q) + i) % N;
      if (!found && credit_q[j] != '0) begin
        found = 1'b1;
        pick  = AW'(j);
      end
    end
  end

  always_comb begin : fsm
    state_d = state_q;
    dest_d  = dest_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (valid_i && found) begin
          state_d = STREAM;
          dest_d  = pick;
        end
      end
      STREAM: begin
        if (hs_last) begin
          state_d = IDLE;
          rr_d    = AW'(wrap_inc(32'(dest_q), N));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A return landing on the consumed index cancels the decrement.
  always_comb begin : credits
    for (int k = 0; k < N; k++) begin
      credit_d[k] = credit_q[k];
      if (hs_last && dest_q == AW'(k)) begin
        if (!credit_ret_i[k]) begin
          credit_d[k] = credit_q[k] - CW'(1);
        end
      end else if (credit_ret_i[k] && credit_q[k] != CMAX) begin
        credit_d[k] = credit_q[k] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      dest_q  <= '0;
      rr_q    <= '0;
      for (int k = 0; k < N; k++) begin
        credit_q[k] <= CMAX;
      end
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      rr_q    <= rr_d;
      for (int k = 0; k < N; k++) begin
        credit_q[k] <= credit_d[k];
      end
    end
  end

  gnrc_stream_demux #(
    .N     (N),
    .DTYPE (DTYPE),
    .AW    (AW)
  ) u_demux (
    .sel_i   (dest_q),
    .data_i  (data_i),
    .valid_i (dmx_valid),
    .last_i  (last_i),
    .ready_o (dmx_ready),
    .data_o  (data_o),
    .valid_o (valid_o),
    .last_o  (last_o),
    .ready_i (ready_i)
  );

  a_no_underflow : assert property (
    @(posedge clk_i) disable iff (rst_i)
    hs_last |-> credit_q[dest_q] != '0
  );

  a_dest_locked : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (state_q == STREAM && !hs_last) |=> $stable(dest_q)
  );

endmodule

// File: tb/tb_gnrc_stream_dispatch.sv
// Bench for gnrc_stream_dispatch: directed scenarios then random
// traffic, all checked against a packet-level credit model.
module tb_gnrc_stream_dispatch;

  localparam int N  = 4;
  localparam int MC = 2;

  typedef logic [7:0] dt_t;

  logic         clk = 1'b0;
  logic         rst;
  dt_t          d_i;
  logic         v_i;
  logic         l_i;
  logic         rdy_o;
  dt_t          d_o [N];
  logic [N-1:0] v_o;
  logic [N-1:0] l_o;
  logic [N-1:0] rdy_i;
  logic [N-1:0] cr_i;
  logic [1:0]   dest_o;
  logic         busy_o;

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt = 0;

  int m_credit [N];
  int m_rr;
  int m_dest;
  bit m_busy;

  always #5 clk = ~clk;

  gnrc_stream_dispatch #(
    .N          (N),
    .DTYPE      (dt_t),
    .MAX_CREDIT (MC)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_i       (d_i),
    .valid_i      (v_i),
    .last_i       (l_i),
    .ready_o      (rdy_o),
    .data_o       (d_o),
    .valid_o      (v_o),
    .last_o       (l_o),
    .ready_i      (rdy_i),
    .credit_ret_i (cr_i),
    .dest_o       (dest_o),
    .busy_o       (busy_o)
  );

  task automatic expect_eq(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_rr   = 0;
    m_dest = 0;
    for (int k = 0; k < N; k++) m_credit[k] = MC;
  endtask

  task automatic drive(
    input bit           r,
    input bit           v,
    input bit           l,
    input logic [N-1:0] rdy,
    input logic [N-1:0] cr
  );
    bit           st;
    logic [N-1:0] ev;
    @(negedge clk);
    rst   = r;
    v_i   = v;
    l_i   = l;
    rdy_i = rdy;
    cr_i  = cr;
    d_i   = 8'($urandom);
    #1;
    st = m_busy && !r;
    ev = (st && v) ? (N'(1) << m_dest) : '0;
    expect_eq("busy", busy_o, st);
    expect_eq("ready", rdy_o, st && rdy[m_dest]);
    expect_eq("valid", v_o, ev);
    expect_eq("last", l_o, {N{l}});
    expect_eq("dest", dest_o, r ? 0 : m_dest);
    for (int k = 0; k < N; k++) expect_eq("data", d_o[k], d_i);
    if (v_i && rdy_o) hs_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (!m_busy) begin
        if (v_i) begin
          for (int i = 0; i < N; i++) begin
            automatic int k = (m_rr + i) % N;
            if (m_credit[k] > 0) begin
              m_busy = 1'b1;
              m_dest = k;
              break;
            end
          end
        end
      end else if (v_i && rdy_i[m_dest] && l_i) begin
        m_credit[m_dest] = m_credit[m_dest] - 1;
        m_rr   = (m_dest + 1) % N;
        m_busy = 1'b0;
      end
      for (int k = 0; k < N; k++) begin
        if (cr_i[k]) begin
          m_credit[k] = m_credit[k] + 1;
          if (m_credit[k] > MC) m_credit[k] = MC;
        end
      end
    end
  endtask

  task automatic send1(input int exp_dest);
    drive(0, 1, 1, '1, '0);
    expect_eq("sel_idle", busy_o, 0);
    tick();
    drive(0, 1, 1, '1, '0);
    expect_eq("sel_dest", dest_o, exp_dest);
    expect_eq("sel_busy", busy_o, 1);
    tick();
  endtask

  task automatic drain(input int exp_pkts);
    hs_cnt = 0;
    repeat (40) begin
      drive(0, 1, 1, '1, '0);
      tick();
    end
    expect_eq("drain_pkts", hs_cnt, exp_pkts);
  endtask

  task automatic refill();
    repeat (MC) begin
      drive(0, 0, 0, '1, '1);
      tick();
    end
  endtask

  initial begin
    rst   = 1'b1;
    v_i   = 1'b0;
    l_i   = 1'b0;
    rdy_i = '0;
    cr_i  = '0;
    d_i   = '0;
    model_reset();

    drive(1, 0, 0, '1, '0);
    tick();
    drive(1, 1, 1, '1, '0);
    tick();
    drive(0, 0, 0, '1, '0);
    expect_eq("rst_busy", busy_o, 0);
    expect_eq("rst_dest", dest_o, 0);
    tick();

    for (int i = 0; i < N; i++) send1(i);
    for (int i = 0; i < N; i++) send1(i);

    drive(0, 0, 0, '1, 4'b0101);
    tick();
    send1(0);
    send1(2);

    repeat (4) begin
      drive(0, 1, 1, '1, '0);
      expect_eq("stall_ready", rdy_o, 0);
      tick();
    end
    drive(0, 1, 1, '1, 4'b1000);
    expect_eq("ret_busy0", busy_o, 0);
    tick();
    drive(0, 1, 1, '1, '0);
    expect_eq("ret_busy1", busy_o, 0);
    tick();
    drive(0, 1, 1, '1, '0);
    expect_eq("ret_dest", dest_o, 3);
    expect_eq("ret_busy2", busy_o, 1);
    tick();

    refill();
    hs_cnt = 0;
    drive(0, 1, 0, '1, '0);
    tick();
    drive(0, 1, 0, '1, '0);
    tick();
    drive(0, 0, 0, '1, '0);
    expect_eq("drop_busy", busy_o, 1);
    tick();
    drive(0, 1, 0, 4'b1110, '0);
    expect_eq("stall_rdy", rdy_o, 0);
    expect_eq("stall_dest", dest_o, 0);
    expect_eq("stall_busy", busy_o, 1);
    tick();
    drive(0, 1, 0, '1, '0);
    tick();
    drive(0, 1, 1, '1, '0);
    tick();
    drive(0, 0, 0, '1, '0);
    expect_eq("pkt3_hs", hs_cnt, 3);
    expect_eq("pkt3_done", busy_o, 0);
    tick();

    send1(1);
    drive(0, 1, 1, '1, '0);
    tick();
    drive(0, 1, 1, '1, 4'b0100);
    expect_eq("cancel_dest", dest_o, 2);
    tick();
    drive(0, 0, 0, '1, 4'b0100);
    tick();
    drain(6);

    refill();
    drive(0, 1, 0, '1, '0);
    tick();
    drive(0, 1, 0, '1, '0);
    tick();
    drive(1, 1, 0, '1, '0);
    expect_eq("mid_rst_v", v_o, 0);
    tick();
    drive(0, 0, 0, '1, '0);
    expect_eq("post_rst_busy", busy_o, 0);
    tick();
    drive(0, 1, 1, '1, '0);
    tick();
    drive(0, 1, 1, '1, '0);
    expect_eq("post_rst_rr", dest_o, 0);
    tick();
    drain(7);

    repeat (3000) begin
      automatic bit           r   = ($urandom_range(0, 199) == 0);
      automatic bit           v   = ($urandom_range(0, 3) != 0);
      automatic bit           l   = ($urandom_range(0, 2) == 0);
      automatic logic [N-1:0] rdy = N'($urandom | $urandom);
      automatic logic [N-1:0] cr  = N'($urandom & $urandom & $urandom);
      drive(r, v, l, rdy, cr);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
